midi_rx_frontend: RTL and testbench
===================================

MIDI_RX_FRONTEND -- requirements
Module: midi_rx_frontend

Interface
REQ-001 Parameter CLK_HZ, default 24000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 31250, MIDI serial bit rate.
REQ-003 Parameter RUN_STAT, default 1, enables running-status expansion (0 = raw byte pass-through).
REQ-004 Parameter FILT_RT, default 1, suppresses realtime bytes 0xF8-0xFF from the output.
REQ-005 i_clk  input  1  single system clock; all logic is on its rising edge.
REQ-006 i_res  input  1  reset, synchronous and active-high.
REQ-007 i_midi_rx  input  1  asynchronous MIDI serial line, idle high.
REQ-008 o_rx_flg  output  1  one-cycle strobe: o_rx_data holds a valid byte.
REQ-009 o_rx_data  output  8  received or re-inserted byte; holds its value between strobes.
REQ-010 o_frame_err  output  1  one-cycle strobe on a stop-bit error.

Function
REQ-011 i_midi_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Oversample tick SHALL fire every DIV = CLK_HZ/(BAUD*16) clocks (integer division); default DIV = 48, so 1 bit = 768 clocks.
REQ-013 Bit FSM states: IDLE, START, DATA, STOP, WAIT_HI.
REQ-014 IDLE -> START on synchronized falling edge; tick counter and sample counter SHALL clear.
REQ-015 START: at sample 8 (mid-bit), line low -> DATA; line high -> IDLE (glitch rejected, no strobe).
REQ-016 DATA: sample every 16 ticks at mid-bit, 8 bits, LSB first, shifted into an 8-bit register.
REQ-017 STOP: at mid-bit, line high -> byte accepted, -> IDLE; line low -> o_frame_err pulse, byte discarded, -> WAIT_HI.
REQ-018 WAIT_HI -> IDLE once line is sampled high; no start detection while in WAIT_HI.
REQ-019 Accepted byte SHALL produce o_rx_flg exactly 1 cycle after the stop-bit sample (direct case).
REQ-020 With FILT_RT=1, bytes 0xF8-0xFF SHALL produce no strobe and SHALL NOT alter running-status or data-count state.
REQ-021 Running-status tracker: status byte 0x80-0xEF SHALL be stored as the running status (valid=1), with expected data count 1 for 0xC0-0xDF, else 2.
REQ-022 Bytes 0xF0-0xF7 SHALL clear running-status valid; they are still forwarded.
REQ-023 Data byte (bit7=0) arriving when the data count is 0 and running status is valid (RUN_STAT=1): output the stored status with o_rx_flg at +1 cycle, then the data byte with o_rx_flg at +2 cycles; data count reloads.
REQ-024 Data byte at count 0 with running status invalid SHALL be forwarded unchanged.
REQ-025 Each forwarded data byte decrements the data count, saturating at 0; a status byte reloads it.
REQ-026 o_rx_flg SHALL never be high for two cycles except for the expansion pair in REQ-023; strobes are at least 2 cycles apart otherwise.
REQ-027 A new byte completing while an expansion pair is pending cannot occur (byte time >> 2 cycles); no queue is required.

Reset
REQ-028 On i_res: o_rx_flg=0, o_rx_data=0x00, o_frame_err=0, FSM=IDLE, counters=0, running status=0x00 invalid, data count=0.
REQ-029 Synchronizer flops SHALL reset to 1 (idle line).
REQ-030 Reset asserted mid-frame SHALL discard the partial byte; after release, reception resumes at the next falling edge.

Structure
REQ-031 Shared package midi_pkg holds the status-range constants (0x80, 0xC0, 0xE0, 0xF0, 0xF8) and the bit-FSM state encoding.
REQ-032 Sub-module midi_uart_rx implements REQ-011 to REQ-018 and outputs a byte strobe, byte and frame error; midi_rx_frontend adds the filtering and running status.
REQ-033 The output connects directly to the decoder's i_rx_flg/i_rx_data with no glue logic.

Verification
REQ-034 Serial 0x90,0x3C,0x64 at 31250 baud -> three strobes, data 0x90,0x3C,0x64, no o_frame_err.
REQ-035 0x90,0x3C,0x64,0x40,0x00 -> strobes 0x90,0x3C,0x64 then 0x90,0x40 on consecutive cycles, then 0x00.
REQ-036 0x90,0x3C,0xF8,0x64 -> 0xF8 produces no strobe; output is 0x90,0x3C,0x64.
REQ-037 Frame with stop bit held low -> one o_frame_err pulse, no o_rx_flg; line high, then 0x80,0x3C,0x00 received correctly.
REQ-038 Low glitch of 200 clocks on the idle line -> no strobe and no error; i_res pulsed mid-byte -> partial byte dropped and the next byte is correct.

Source files
------------

// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
// Module : midi_pkg
// Brief  : Shared MIDI status-range constants and bit-FSM state encoding.
// Rev    : 1.0
// ============================================================================
package midi_pkg;

    localparam logic [7:0] c_STATUS_MIN  = 8'h80;
    localparam logic [7:0] c_ONE_DATA    = 8'hC0;
    localparam logic [7:0] c_TWO_DATA    = 8'hE0;
    localparam logic [7:0] c_SYSTEM_MIN  = 8'hF0;
    localparam logic [7:0] c_REALTIME    = 8'hF8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT_HI = 3'd4
    } bit_state_e;

    // Program change and channel pressure carry one data byte; other channel messages carry two.
    function automatic logic [1:0] data_count(input logic [7:0] status);
        return ((status >= c_ONE_DATA) && (status < c_TWO_DATA)) ? 2'd1 : 2'd2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/midi_uart_rx.sv
`default_nettype none
// ============================================================================
// Module : midi_uart_rx
// Brief  : 16x-oversampled 8N1 receiver with synchronizer and framing check.
// Rev    : 1.0
// ============================================================================
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int DIV = 48
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_rx,
    output logic       o_byte_vld,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);

    localparam int c_DIV = (DIV < 1) ? 1 : DIV;
    localparam int c_TW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;

    logic             r_sync1_q;
    logic             r_sync2_q;
    logic             r_prev_q;
    bit_state_e       r_state_q,  w_state_d;
    logic [c_TW-1:0]  r_tick_q,   w_tick_d;
    logic [3:0]       r_samp_q,   w_samp_d;
    logic [2:0]       r_bit_q,    w_bit_d;
    logic [7:0]       r_shift_q,  w_shift_d;
    logic             w_tick;
    logic             w_accept;
    logic             w_ferr;

    assign w_tick = (r_tick_q == c_TW'(c_DIV - 1));

    always_comb begin
        w_state_d = r_state_q;
        w_tick_d  = w_tick ? '0 : r_tick_q + 1'b1;
        w_samp_d  = r_samp_q;
        w_bit_d   = r_bit_q;
        w_shift_d = r_shift_q;
        w_accept  = 1'b0;
        w_ferr    = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                w_tick_d = '0;
                w_samp_d = 4'd0;
                if (r_prev_q && !r_sync2_q) begin
                    w_state_d = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_samp_d = r_samp_q + 4'd1;
                    if (r_samp_q == 4'd7) begin
                        w_samp_d  = 4'd0;
                        w_bit_d   = 3'd0;
                        w_state_d = r_sync2_q ? ST_IDLE : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_samp_d = r_samp_q + 4'd1;
                    if (r_samp_q == 4'd15) begin
                        w_shift_d = {r_sync2_q, r_shift_q[7:1]};
                        w_bit_d   = r_bit_q + 3'd1;
                        if (r_bit_q == 3'd7) begin
                            w_state_d = ST_STOP;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_samp_d = r_samp_q + 4'd1;
                    if (r_samp_q == 4'd15) begin
                        w_accept  = r_sync2_q;
                        w_ferr    = !r_sync2_q;
                        w_state_d = r_sync2_q ? ST_IDLE : ST_WAIT_HI;
                    end
                end
            end
            ST_WAIT_HI: begin
                w_tick_d = '0;
                w_samp_d = 4'd0;
                if (r_sync2_q) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Synchronizer idles high so reset never looks like a start edge.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_sync1_q <= 1'b1;
            r_sync2_q <= 1'b1;
            r_prev_q  <= 1'b1;
            r_state_q <= ST_IDLE;
            r_tick_q  <= '0;
            r_samp_q  <= 4'd0;
            r_bit_q   <= 3'd0;
            r_shift_q <= 8'h00;
        end else begin
            r_sync1_q <= i_rx;
            r_sync2_q <= r_sync1_q;
            r_prev_q  <= r_sync2_q;
            r_state_q <= w_state_d;
            r_tick_q  <= w_tick_d;
            r_samp_q  <= w_samp_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
        end
    end

    // Strobes are asserted in the stop-sample cycle; the frontend registers them.
    assign o_byte_vld  = w_accept;
    assign o_byte      = r_shift_q;
    assign o_frame_err = w_ferr;

endmodule
`default_nettype wire

// File: rtl/midi_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module : midi_rx_frontend
// Brief  : MIDI receiver with realtime filtering and running-status expansion.
// Rev    : 1.0
// ============================================================================
module midi_rx_frontend
    import midi_pkg::*;
#(
    parameter int CLK_HZ   = 24000000,
    parameter int BAUD     = 31250,
    parameter int RUN_STAT = 1,
    parameter int FILT_RT  = 1
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_midi_rx,
    output logic       o_rx_flg,
    output logic [7:0] o_rx_data,
    output logic       o_frame_err
);

    localparam int c_DIV = CLK_HZ / (BAUD * 16);

    logic       w_byte_vld;
    logic [7:0] w_byte;
    logic       w_uart_ferr;

    midi_uart_rx #(
        .DIV (c_DIV)
    ) u_uart (
        .i_clk       (i_clk),
        .i_res       (i_res),
        .i_rx        (i_midi_rx),
        .o_byte_vld  (w_byte_vld),
        .o_byte      (w_byte),
        .o_frame_err (w_uart_ferr)
    );

    logic       r_flg_q,       w_flg_d;
    logic [7:0] r_data_q,      w_data_d;
    logic       r_ferr_q,      w_ferr_d;
    logic       r_pend_q,      w_pend_d;
    logic [7:0] r_pend_data_q, w_pend_data_d;
    logic [7:0] r_rs_q,        w_rs_d;
    logic       r_rs_vld_q,    w_rs_vld_d;
    logic [1:0] r_cnt_q,       w_cnt_d;
    logic       w_is_rt;

    always_comb begin
        w_flg_d       = 1'b0;
        w_data_d      = r_data_q;
        w_ferr_d      = w_uart_ferr;
        w_pend_d      = 1'b0;
        w_pend_data_d = r_pend_data_q;
        w_rs_d        = r_rs_q;
        w_rs_vld_d    = r_rs_vld_q;
        w_cnt_d       = r_cnt_q;
        w_is_rt       = (w_byte >= c_REALTIME);
        if (r_pend_q) begin
            w_flg_d  = 1'b1;
            w_data_d = r_pend_data_q;
        end else if (w_byte_vld && !((FILT_RT != 0) && w_is_rt)) begin
            w_flg_d  = 1'b1;
            w_data_d = w_byte;
            if (w_byte >= c_STATUS_MIN) begin
                if (w_byte < c_SYSTEM_MIN) begin
                    w_rs_d     = w_byte;
                    w_rs_vld_d = 1'b1;
                    w_cnt_d    = data_count(w_byte);
                end else if (!w_is_rt) begin
                    w_rs_vld_d = 1'b0;
                end
            end else if ((RUN_STAT != 0) && (r_cnt_q == 2'd0) && r_rs_vld_q) begin
                // Re-insert the stored status now and the data byte on the next cycle.
                w_data_d      = r_rs_q;
                w_pend_d      = 1'b1;
                w_pend_data_d = w_byte;
                w_cnt_d       = data_count(r_rs_q) - 2'd1;
            end else if (r_cnt_q != 2'd0) begin
                w_cnt_d = r_cnt_q - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_flg_q       <= 1'b0;
            r_data_q      <= 8'h00;
            r_ferr_q      <= 1'b0;
            r_pend_q      <= 1'b0;
            r_pend_data_q <= 8'h00;
            r_rs_q        <= 8'h00;
            r_rs_vld_q    <= 1'b0;
            r_cnt_q       <= 2'd0;
        end else begin
            r_flg_q       <= w_flg_d;
            r_data_q      <= w_data_d;
            r_ferr_q      <= w_ferr_d;
            r_pend_q      <= w_pend_d;
            r_pend_data_q <= w_pend_data_d;
            r_rs_q        <= w_rs_d;
            r_rs_vld_q    <= w_rs_vld_d;
            r_cnt_q       <= w_cnt_d;
        end
    end

    assign o_rx_flg    = r_flg_q;
    assign o_rx_data   = r_data_q;
    assign o_frame_err = r_ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module : tb_midi_rx_frontend
// Brief  : Directed self-checking bench for midi_rx_frontend.
// Rev    : 1.0
// ============================================================================
module tb_midi_rx_frontend;

    // 2 MHz clock gives 4 clocks per oversample tick, 64 clocks per bit.
    localparam int c_CLK_HZ = 2000000;
    localparam int c_BIT    = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       flg;
    logic [7:0] data;
    logic       ferr;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    int unsigned n_ferr = 0;
    logic [7:0]  q_data[$];
    int unsigned q_cyc[$];

    midi_rx_frontend #(
        .CLK_HZ   (c_CLK_HZ),
        .BAUD     (31250),
        .RUN_STAT (1),
        .FILT_RT  (1)
    ) dut (
        .i_clk       (clk),
        .i_res       (rst),
        .i_midi_rx   (rx),
        .o_rx_flg    (flg),
        .o_rx_data   (data),
        .o_frame_err (ferr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (flg) begin
            q_data.push_back(data);
            q_cyc.push_back(cyc);
        end
        if (ferr) n_ferr = n_ferr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n * c_BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bits(1);
        end
        rx = stop_lvl;
        wait_bits(1);
        rx = 1'b1;
    endtask

    task automatic chk_seq(input string tag, input int base, input logic [7:0] exp[$]);
        logic [31:0] obs;
        chk({tag, "_count"}, 32'(q_data.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            obs = (base + i < q_data.size()) ? 32'(q_data[base + i]) : 32'hDEAD;
            chk($sformatf("%s_byte%0d", tag, i), obs, 32'(exp[i]));
        end
    endtask

    initial begin
        int base;
        int fbase;

        // Reset state
        repeat (5) @(negedge clk);
        chk("rst_flg", 32'(flg), 32'h0);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_ferr", 32'(ferr), 32'h0);
        rst = 1'b0;
        wait_bits(2);

        // Plain note-on
        base = q_data.size(); fbase = n_ferr;
        send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
        wait_bits(2);
        chk_seq("note_on", base, '{8'h90, 8'h3C, 8'h64});
        chk("note_on_ferr", 32'(n_ferr - fbase), 32'd0);
        chk("data_hold", 32'(data), 32'h64);

        // Running status expansion
        base = q_data.size();
        send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
        send_byte(8'h40, 1'b1); send_byte(8'h00, 1'b1);
        wait_bits(2);
        chk_seq("run_stat", base, '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h40, 8'h00});
        if (q_data.size() >= base + 5)
            chk("run_stat_pair_gap", q_cyc[base + 4] - q_cyc[base + 3], 32'd1);
        else
            chk("run_stat_pair_present", 32'(q_data.size() - base), 32'd6);

        // Realtime byte filtered mid-message
        base = q_data.size();
        send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1);
        send_byte(8'hF8, 1'b1); send_byte(8'h64, 1'b1);
        wait_bits(2);
        chk_seq("rt_filter", base, '{8'h90, 8'h3C, 8'h64});

        // Stop bit held low, then recovery
        base = q_data.size(); fbase = n_ferr;
        send_byte(8'hA5, 1'b0);
        wait_bits(2);
        chk("ferr_count", 32'(n_ferr - fbase), 32'd1);
        chk("ferr_no_strobe", 32'(q_data.size() - base), 32'd0);
        send_byte(8'h80, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h00, 1'b1);
        wait_bits(2);
        chk_seq("after_ferr", base, '{8'h80, 8'h3C, 8'h00});
        chk("after_ferr_ferr", 32'(n_ferr - fbase), 32'd1);

        // Short low glitch on idle line
        base = q_data.size(); fbase = n_ferr;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        wait_bits(3);
        chk("glitch_strobes", 32'(q_data.size() - base), 32'd0);
        chk("glitch_ferr", 32'(n_ferr - fbase), 32'd0);

        // Reset mid-byte drops the partial frame
        base = q_data.size(); fbase = n_ferr;
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            wait_bits(1);
        end
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_data", 32'(data), 32'h00);
        chk("midrst_flg", 32'(flg), 32'h0);
        rst = 1'b0;
        wait_bits(2);
        chk("midrst_no_strobe", 32'(q_data.size() - base), 32'd0);
        send_byte(8'h3C, 1'b1);
        wait_bits(2);
        chk_seq("after_rst", base, '{8'h3C});
        chk("after_rst_ferr", 32'(n_ferr - fbase), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
